// File: rtl/line_sample_packer.sv
// Packs 12-bit line samples into a framed 32-bit word stream (header + two samples per word)
// and buffers it in a show-ahead FIFO with valid/ready output and overflow accounting.
module line_sample_packer #(
    parameter int          SAMPLES_PER_LINE = 1000,
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [7:0]  HDR_TAG          = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start_i,
    input  logic        line_start_i,
    input  logic [5:0]  vs_cnt_i,
    input  logic [9:0]  hs_cnt_i,
    input  logic [11:0] sample_i,
    input  logic        sample_vld_i,
    output logic [31:0] out_data_o,
    output logic        out_sop_o,
    output logic        out_eop_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        overflow_o,
    output logic [15:0] drop_cnt_o
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0]   LAST    = 16'(SAMPLES_PER_LINE - 1);

    typedef enum logic [2:0] {IDLE, WAIT_LINE, HEADER, PACK, DONE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   smp_cnt;
    logic          half_vld;
    logic [11:0]   half_q;
    logic [5:0]    vs_q;
    logic [9:0]    hs_q;
    logic          wr_en;
    logic [33:0]   wr_word;   // {sop, eop, data}
    logic          pack_smp;

    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          rd, full, wr_ok, drop;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // frame_start_i takes priority in every state, including IDLE
    always_comb begin
        state_nxt = state;
        if (frame_start_i) begin
            state_nxt = line_start_i ? HEADER : WAIT_LINE;
        end else begin
            case (state)
                WAIT_LINE, DONE: if (line_start_i) state_nxt = HEADER;
                HEADER:          state_nxt = PACK;
                PACK: begin
                    if (line_start_i)                         state_nxt = HEADER;
                    else if (sample_vld_i && smp_cnt == LAST) state_nxt = DONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_word = '0;
        if (frame_start_i) begin
            if (state == PACK && half_vld) begin
                wr_en   = 1'b1;
                wr_word = {2'b01, 4'h0, half_q, 16'h0};
            end
        end else begin
            case (state)
                HEADER: begin
                    wr_en   = 1'b1;
                    wr_word = {2'b10, HDR_TAG, 2'b00, vs_q, 6'b0, hs_q};
                end
                PACK: begin
                    if (line_start_i) begin
                        wr_en   = half_vld;
                        wr_word = {2'b01, 4'h0, half_q, 16'h0};
                    end else if (sample_vld_i && smp_cnt[0]) begin
                        wr_en   = 1'b1;
                        wr_word = {1'b0, smp_cnt == LAST, 4'h0, half_q, 4'h0, sample_i};
                    end
                end
                default: ;
            endcase
        end
    end

    assign pack_smp = (state == PACK) && sample_vld_i && !line_start_i && !frame_start_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_cnt  <= '0;
            half_vld <= 1'b0;
        end else begin
            if (state == HEADER || frame_start_i || (state == PACK && line_start_i))
                half_vld <= 1'b0;
            else if (pack_smp)
                half_vld <= ~smp_cnt[0];
            if (state == HEADER)
                smp_cnt <= '0;
            else if (pack_smp)
                smp_cnt <= smp_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (pack_smp && !smp_cnt[0]) half_q <= sample_i;
        if (line_start_i && state_nxt == HEADER) begin
            vs_q <= vs_cnt_i;
            hs_q <= hs_cnt_i;
        end
    end

    // Output FIFO: a read in the same cycle frees the slot for a write when full
    assign rd    = out_valid_o && out_ready_i;
    assign full  = (fifo_cnt == DEPTH_C);
    assign wr_ok = wr_en && (!full || rd);
    assign drop  = wr_en && !wr_ok;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd)    rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign out_valid_o = (fifo_cnt != '0);
    assign out_data_o  = out_valid_o ? mem[rd_ptr][31:0] : 32'h0;
    assign out_sop_o   = out_valid_o & mem[rd_ptr][33];
    assign out_eop_o   = out_valid_o & mem[rd_ptr][32];

    // A new frame restarts overflow accounting; a flush drop on that edge belongs to the old frame
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (frame_start_i && state != IDLE) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            drop_cnt_o <= sat_inc(drop_cnt_o);
        end
    end

endmodule

// File: tb/tb_line_sample_packer.sv
// Randomized and directed bench for line_sample_packer against a line/queue-level reference model.
module tb_line_sample_packer;

    localparam int SPL   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs = 1'b0, ls = 1'b0, sv = 1'b0, rdy = 1'b0;
    logic [5:0]  vs = '0;
    logic [9:0]  hs = '0;
    logic [11:0] smp = '0;
    logic [31:0] out_data;
    logic        out_sop, out_eop, out_valid, overflow;
    logic [15:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    line_sample_packer #(.SAMPLES_PER_LINE(SPL), .FIFO_DEPTH(DEPTH), .HDR_TAG(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .frame_start_i(fs), .line_start_i(ls),
        .vs_cnt_i(vs), .hs_cnt_i(hs), .sample_i(smp), .sample_vld_i(sv),
        .out_data_o(out_data), .out_sop_o(out_sop), .out_eop_o(out_eop),
        .out_valid_o(out_valid), .out_ready_i(rdy),
        .overflow_o(overflow), .drop_cnt_o(drop_cnt)
    );

    // reference model: words are {sop, eop, data}
    bit          m_frame, m_hdr, m_pack, m_half_vld;
    int          m_cnt;
    logic [11:0] m_half;
    logic [5:0]  m_vs;
    logic [9:0]  m_hs;
    logic [33:0] m_q[$];
    logic [33:0] got[$];
    bit          m_ovf;
    int          m_drop;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit have = 0;
        bit clr  = 0;
        logic [33:0] w = '0;
        if (rst) begin
            m_frame = 0; m_hdr = 0; m_pack = 0; m_half_vld = 0; m_cnt = 0;
            m_ovf = 0; m_drop = 0; m_q.delete();
            return;
        end
        if (rdy && m_q.size() > 0) begin
            got.push_back({out_sop, out_eop, out_data});
            void'(m_q.pop_front());
        end
        if (!m_frame) begin
            if (fs) begin
                m_frame = 1;
                if (ls) begin m_vs = vs; m_hs = hs; m_hdr = 1; end
            end
        end else if (fs) begin
            clr = 1;
            if (m_pack && m_half_vld) begin have = 1; w = {2'b01, 4'h0, m_half, 16'h0}; end
            m_pack = 0; m_hdr = 0; m_half_vld = 0;
            if (ls) begin m_vs = vs; m_hs = hs; m_hdr = 1; end
        end else if (m_hdr) begin
            have = 1; w = {2'b10, 8'hA5, 2'b00, m_vs, 6'b0, m_hs};
            m_hdr = 0; m_pack = 1; m_cnt = 0; m_half_vld = 0;
        end else if (m_pack) begin
            if (ls) begin
                if (m_half_vld) begin have = 1; w = {2'b01, 4'h0, m_half, 16'h0}; end
                m_half_vld = 0; m_pack = 0;
                m_vs = vs; m_hs = hs; m_hdr = 1;
            end else if (sv) begin
                if (m_cnt % 2 == 0) begin
                    m_half = smp; m_half_vld = 1;
                end else begin
                    have = 1;
                    w = {1'b0, m_cnt == SPL - 1, 4'h0, m_half, 4'h0, smp};
                    m_half_vld = 0;
                    if (m_cnt == SPL - 1) m_pack = 0;
                end
                m_cnt++;
            end
        end else if (ls) begin
            m_vs = vs; m_hs = hs; m_hdr = 1;
        end
        if (clr) begin
            m_ovf = 0; m_drop = 0;
            if (have && m_q.size() < DEPTH) m_q.push_back(w);
        end else if (have) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
    endtask

    task automatic check_outputs();
        cmp("valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            cmp("data", out_data, m_q[0][31:0]);
            cmp("sop", out_sop, m_q[0][33]);
            cmp("eop", out_eop, m_q[0][32]);
        end
        cmp("overflow", overflow, m_ovf);
        cmp("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic step(input bit f, input bit l, input bit v, input logic [11:0] s, input bit r);
        fs = f; ls = l; sv = v; smp = s; rdy = r;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic line4(input logic [9:0] h, input bit r);
        hs = h;
        step(0, 1, 0, 0, r);
        step(0, 0, 0, 0, r);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 12'(h * 4 + k), r);
    endtask

    initial begin
        int b;
        bit tog;
        rst = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cmp("reset_valid", out_valid, 0);
        cmp("reset_data", {out_sop, out_eop, out_data}, 34'h0);
        cmp("reset_drop", drop_cnt, 0);
        rst = 0;

        // basic line, header latency
        b = got.size();
        step(1, 0, 0, 0, 1);
        vs = 3; hs = 7;
        step(0, 1, 0, 0, 1);
        cmp("hdr_not_yet", out_valid, 0);
        step(0, 0, 1, 12'h7FF, 0);
        cmp("hdr_latency", out_valid, 1);
        for (int k = 1; k <= 5; k++) step(0, 0, 1, 12'(k), 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
        cmp("t1_count", got.size() - b, 3);
        cmp("t1_w0", got[b], 34'h2A5030007);
        cmp("t1_w1", got[b + 1], 34'h000010002);
        cmp("t1_w2", got[b + 2], 34'h100030004);

        // early end with a pending half word
        b = got.size();
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 12'hABC, 1);
        step(0, 0, 1, 12'h123, 1);
        step(0, 0, 1, 12'hFFF, 1);
        hs = 8;
        step(0, 1, 1, 12'h555, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
        cmp("t2_count", got.size() - b, 4);
        cmp("t2_w1", got[b + 1], 34'h00ABC0123);
        cmp("t2_w2", got[b + 2], 34'h10FFF0000);
        cmp("t2_w3", got[b + 3], 34'h2A5030008);

        // early end after an even count: no pad word
        b = got.size();
        step(0, 0, 1, 12'h055, 1);
        step(0, 0, 1, 12'h0AA, 1);
        hs = 9;
        step(0, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
        cmp("t3_count", got.size() - b, 2);
        cmp("t3_w0", got[b], 34'h0005500AA);
        cmp("t3_w1", got[b + 1], 34'h2A5030009);

        // overflow: 20 words into 16 entries
        hs = 0;
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 12'(k), 0);
        for (int l = 1; l < 6; l++) line4(10'(l), 0);
        hs = 6;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 12'h0A1, 0);
        step(0, 0, 1, 12'h0A2, 0);
        step(0, 0, 0, 0, 0);
        cmp("t4_overflow", overflow, 1);
        cmp("t4_drop", drop_cnt, 4);
        b = got.size();
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1);
        cmp("t4_drained", got.size() - b, 16);
        cmp("t4_first", got[b], 34'h2A5030000);
        step(1, 0, 0, 0, 1);
        cmp("t4_ovf_clr", overflow, 0);
        cmp("t4_drop_clr", drop_cnt, 0);

        // backpressure toggling
        b = got.size();
        tog = 0;
        hs = 20;
        for (int l = 0; l < 2; l++) begin
            fs = 0; ls = 1; sv = 0; smp = 0; rdy = tog; tog = ~tog;
            model_step(); @(negedge clk); check_outputs();
            for (int k = 0; k < 5; k++) begin
                step(0, 0, k != 0, 12'(100 + l * 4 + k), tog);
                tog = ~tog;
            end
        end
        for (int k = 0; k < 20; k++) begin step(0, 0, 0, 0, tog); tog = ~tog; end
        cmp("t5_count", got.size() - b, 6);

        // reset mid-packet
        line4(10'd30, 0);
        hs = 31;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 12'h011, 0);
        step(0, 0, 1, 12'h022, 0);
        cmp("t6_before", out_valid, 1);
        rst = 1;
        step(0, 0, 0, 0, 0);
        rst = 0;
        cmp("t6_valid", out_valid, 0);
        cmp("t6_drop", drop_cnt, 0);
        b = got.size();
        step(0, 1, 0, 0, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 12'(k), 1);
        cmp("t6_idle", out_valid, 0);
        cmp("t6_none", got.size() - b, 0);

        // random traffic
        for (int c = 0; c < 6000; c++) begin
            bit stall;
            stall = ((c / 500) % 2) == 1;
            rst = ($urandom_range(0, 2999) == 0);
            vs = 6'($urandom);
            hs = 10'($urandom);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 9) < 7,
                 12'($urandom),
                 stall ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8));
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/line_sample_packer.md
Name: line_sample_packer

Overview:
Downstream of the AD sampling stage. Consumes 12-bit samples with their FIFO write strobe, plus the line/frame sync pulses and line/frame counters, and produces a framed 32-bit word stream for the upload path. Each line becomes one packet: a header word carrying the frame and line counters, then samples packed two per word. A registered output FIFO with valid/ready handshake decouples the output; overflow is detected and counted.

Parameters:
SAMPLES_PER_LINE, 1000, max samples packed per line; even, 2..65534
FIFO_DEPTH, 16, output FIFO entries; power of two, >=4
HDR_TAG, 8'hA5, tag in header bits [31:24]

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_start_i  in  1  one-cycle pulse, vsync rising edge
line_start_i  in  1  one-cycle pulse, hsync rising edge
vs_cnt_i  in  6  frame counter from sampler, sampled on line_start_i
hs_cnt_i  in  10  line counter from sampler, sampled on line_start_i
sample_i  in  12  sample data
sample_vld_i  in  1  sample strobe (sampler FIFO write enable)
out_data_o  out  32  packed word
out_sop_o  out  1  word is a header
out_eop_o  out  1  last word of a line
out_valid_o  out  1  FIFO not empty
out_ready_i  in  1  consumer accepts word when valid&&ready
overflow_o  out  1  sticky: a word was dropped this frame
drop_cnt_o  out  16  dropped words, saturating at 16'hFFFF

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, FIFO empty, out_valid_o=0, out_data_o=0, out_sop_o=0, out_eop_o=0, overflow_o=0, drop_cnt_o=0, half-word register empty, sample count 0. Reset mid-packet discards everything, no flush.
- States: IDLE, WAIT_LINE, HEADER, PACK, DONE.
- IDLE: ignores all but frame_start_i -> WAIT_LINE (or HEADER if line_start_i in same cycle).
- frame_start_i in any non-IDLE state: flush pending half word (see below), clear overflow_o and drop_cnt_o, -> WAIT_LINE; with line_start_i same cycle -> HEADER.
- WAIT_LINE / DONE: line_start_i latches vs_cnt_i, hs_cnt_i -> HEADER. Samples ignored.
- HEADER (exactly one cycle): write {HDR_TAG, 2'b0, vs[5:0], 6'b0, hs[9:0]}, sop=1, eop=0; -> PACK; clear sample count. sample_vld_i in this cycle discarded.
- PACK: on sample_vld_i, even-index sample stored in half register; odd-index sample writes {4'h0, even_sample, 4'h0, odd_sample}, sop=0. Word containing sample SAMPLES_PER_LINE-1 has eop=1 -> DONE.
- PACK + line_start_i (line ended early): if half register holds a sample, write {4'h0, even_sample, 16'h0} with eop=1; if empty, no write (previous word keeps eop=0). Then -> HEADER, latching new counters. line_start_i wins over simultaneous sample_vld_i (sample discarded).
- At most one FIFO write per cycle; the cases above never coincide.
- FIFO: show-ahead, registered; word written at edge N visible at edge N+1 if FIFO was empty. Line_start at cycle 0 -> header on out_valid_o at cycle 2. out_data/sop/eop stable while valid && !ready. Simultaneous read and write when full: read frees slot, write accepted. Full means FIFO_DEPTH entries.
- Write while full (and no read same cycle): word dropped, overflow_o=1 next cycle, drop_cnt_o+1 saturating. Packing state advances as if written.
- Counters: sample count 16 bits, compared to SAMPLES_PER_LINE-1.

Test Plan:
- Reset, frame_start, line_start with vs=3, hs=7, then 4 samples 0x001..0x004, SAMPLES_PER_LINE=4, ready=1 -> words 0xA5030007 (sop), 0x00010002, 0x00030004 (eop); state DONE, 5th sample ignored.
- SAMPLES_PER_LINE=1000, line_start, 3 samples 0xABC,0x123,0xFFF, then line_start hs=8 -> 0x0ABC0123, 0x0FFF0000 (eop), then header 0xA5030008.
- Line_start after exactly 2 samples -> no pad word; next header follows directly; last data word eop=0.
- ready=0, FIFO_DEPTH=16, push 20 words -> 16 held, overflow_o=1, drop_cnt_o=4; then ready=1 drains 16 in order; frame_start clears overflow_o and drop_cnt_o to 0.
- Backpressure toggling ready every cycle -> each word presented until accepted, no duplication/loss, order preserved.
- rst=1 mid-PACK with FIFO holding 5 words -> next cycle out_valid_o=0, all counters 0, IDLE; line_start without frame_start produces no output.
